idct_coeff_packer: RTL and testbench

Front-end companion to `IDCT`. It accepts a serial stream of signed `WIN`-bit DCT coefficients over a valid/ready handshake and assembles 64 of them into an 8x8 block. It presents the block on the flat `64*WIN`-bit `x` bus that `IDCT` consumes. A latency tracker asserts `res_valid` exactly when the pipelined `IDCT` output for each handed-off block is valid.

---
 rtl/idct_coeff_packer.sv | 97 +++++++++
 tb/tb_idct_coeff_packer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_coeff_packer.sv
// Serial coefficient packer feeding the 8x8 IDCT: assembles 64 samples into a flat block bus
// and tracks IDCT latency. Define IDCT_PACKER_ZIGZAG_EN to accept JPEG zig-zag input order.
module idct_coeff_packer #(
    parameter int WIN     = 12,
    parameter int LATENCY = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIN-1:0]       in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [64*WIN-1:0]    x,
    output logic                 x_valid,
    input  logic                 x_ready,
    output logic                 res_valid
);

    logic [5:0]         cnt;
    logic [5:0]         wr_idx;
    logic               shadow_full;
    logic               accept;
    logic               transfer;
    logic [WIN-1:0]     shadow [64];
    logic [LATENCY-1:0] track;

`ifdef IDCT_PACKER_ZIGZAG_EN
    // Scan position -> raster index for the standard JPEG zig-zag order.
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    always_comb begin
        wr_idx = ZIGZAG[cnt];
    end
`else
    always_comb begin
        wr_idx = cnt;
    end
`endif

    always_comb begin
        in_ready = !shadow_full;
        accept   = in_valid && !shadow_full;
        transfer = shadow_full && (!x_valid || x_ready);
    end

    // Shadow contents are don't-care after reset; cnt decides what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            shadow[wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            shadow_full <= 1'b0;
            x           <= '0;
            x_valid     <= 1'b0;
            track       <= '0;
            res_valid   <= 1'b0;
        end else begin
            // accept and transfer are mutually exclusive, so shadow_full has one writer per edge.
            if (accept) begin
                cnt <= cnt + 6'd1;
                if (cnt == 6'd63) begin
                    shadow_full <= 1'b1;
                end
            end

            if (transfer) begin
                for (int unsigned k = 0; k < 64; k++) begin
                    x[k*WIN +: WIN] <= shadow[k[5:0]];
                end
                x_valid     <= 1'b1;
                shadow_full <= 1'b0;
            end else if (x_valid && x_ready) begin
                x_valid <= 1'b0;
            end

            // LATENCY stages plus the output register: a handshake at edge H shows at H+LATENCY.
            track[0] <= x_valid && x_ready;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                track[i] <= track[i-1];
            end
            res_valid <= track[LATENCY-1];
        end
    end

endmodule

// File: tb/tb_idct_coeff_packer.sv
// Self-checking bench for idct_coeff_packer: block-level reference model compared every cycle,
// plus directed literal checks. Zig-zag expectations follow IDCT_PACKER_ZIGZAG_EN.
module tb_idct_coeff_packer;

    localparam int WIN = 12;
    localparam int LAT = 26;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [WIN-1:0]    in_data;
    logic              in_valid;
    logic              in_ready;
    logic [64*WIN-1:0] x;
    logic              x_valid;
    logic              x_ready;
    logic              res_valid;

    always #5 clk = ~clk;

    idct_coeff_packer #(.WIN(WIN), .LATENCY(LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .res_valid(res_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic signed [WIN-1:0] el(input int k);
        return x[k*WIN +: WIN];
    endfunction

    // ---------------- reference model ----------------
    int             pos_of [64];   // n-th accepted sample of a block -> raster index
    int             zn;
    logic [WIN-1:0] m_blk [64];
    logic [WIN-1:0] m_x   [64];
    int             fill_n  = 0;
    bit             m_xv    = 0;
    int             cyc     = 0;
    int             hs_q[$];
    bit             started = 0;
    bit             m_hs, m_acc, m_xfer;

    initial begin
`ifdef IDCT_PACKER_ZIGZAG_EN
        zn = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    pos_of[zn] = r * 8 + (s - r);
                    zn++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    pos_of[zn] = r * 8 + (s - r);
                    zn++;
                end
            end
        end
`else
        for (int i = 0; i < 64; i++) pos_of[i] = i;
`endif
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_n = 0;
            m_xv   = 0;
            for (int k = 0; k < 64; k++) m_x[k] = '0;
            hs_q.delete();
        end else begin
            cyc++;
            m_hs   = m_xv && x_ready;
            m_acc  = in_valid && (fill_n < 64);
            m_xfer = (fill_n == 64) && (!m_xv || x_ready);
            if (m_hs) hs_q.push_back(cyc);
            if (m_xfer) begin
                for (int k = 0; k < 64; k++) m_x[k] = m_blk[k];
                m_xv   = 1;
                fill_n = 0;
            end else if (m_hs) begin
                m_xv = 0;
            end
            if (m_acc) begin
                m_blk[pos_of[fill_n]] = in_data;
                fill_n++;
            end
            while (hs_q.size() > 0 && hs_q[0] + LAT < cyc) void'(hs_q.pop_front());
        end
        started = 1;
    end

    function automatic bit exp_res();
        foreach (hs_q[i]) if (hs_q[i] + LAT == cyc) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            int bad;
            chk("in_ready", in_ready, fill_n != 64);
            chk("x_valid", x_valid, m_xv);
            chk("res_valid", res_valid, exp_res());
            bad = -1;
            for (int k = 63; k >= 0; k--) if (x[k*WIN +: WIN] !== m_x[k]) bad = k;
            n_checks++;
            if (bad < 0) n_pass++;
            else $display("FAIL x_elem[%0d] at cycle %0d: got %0d, expected %0d",
                          bad, cyc, $signed(x[bad*WIN +: WIN]), $signed(m_x[bad]));
        end
    end

    bit cnt_en = 0;
    int rv_hi  = 0;
    always @(negedge clk) if (cnt_en && res_valid) rv_hi++;

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIN-1:0] v);
        int t = 0;
        in_data  = v;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) chk("send_timeout", 1, 0);
        step();
    endtask

    task automatic wait_xv();
        int t = 0;
        while (!x_valid && t < 10) begin
            step();
            t++;
        end
        chk("wait_x_valid", x_valid, 1);
    endtask

    initial begin
        int k, rv, bad;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        x_ready  = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_x_valid", x_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_x_zero", x == '0, 1);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);

        // First block, x free and consumer ready
        x_ready = 1'b1;
`ifdef IDCT_PACKER_ZIGZAG_EN
        for (int i = 0; i < 64; i++) send(WIN'(i));
`else
        for (int i = 0; i < 64; i++) send(WIN'(-i));
`endif
        in_valid = 1'b0;
        step();
        chk("first_x_valid", x_valid, 1);
`ifdef IDCT_PACKER_ZIGZAG_EN
        chk("zz_el8", el(8), 2);
        chk("zz_el16", el(16), 3);
        chk("zz_el63", el(63), 63);
        chk("zz_el2", el(2), 5);
`else
        chk("raster_el0", el(0), 0);
        chk("raster_el1", el(1), -1);
        chk("raster_el37", el(37), -37);
        chk("raster_el63", el(63), -63);
`endif
        k = 0;
        while (!res_valid && k < 60) begin
            step();
            k++;
        end
        chk("res_latency_edges", k, 27);
        step();
        chk("res_single_cycle", res_valid, 0);

        // Backpressure: two blocks with x held
        x_ready = 1'b0;
        for (int i = 0; i < 64; i++) send(WIN'(200 + i));
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 64; i++) send(WIN'(300 + i));
        in_valid = 1'b0;
        repeat (3) step();
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_x_holds_b1_el0", el(0), 200);
        chk("bp_x_holds_b1_el63", el(63), 263);
        x_ready = 1'b1;
        step();
        x_ready = 1'b0;
        chk("bp_x_valid_stays", x_valid, 1);
        chk("bp_x_b2_el0", el(0), 300);
        chk("bp_x_b2_el63", el(63), 363);
        chk("bp_in_ready_back", in_ready, 1);
        x_ready = 1'b1;
        repeat (2) step();

        // Throttled input
        for (int i = 0; i < 64; i++) begin
            k = 0;
            while ($urandom_range(1, 0) == 0 && k < 8) begin
                in_valid = 1'b0;
                step();
                k++;
            end
            send(WIN'(100 + i));
        end
        in_valid = 1'b0;
        wait_xv();
        chk("thr_el0", el(0), 100);
        chk("thr_el63", el(63), 163);
        repeat (40) step();

        // Mid-block reset with a result in flight
        x_ready = 1'b0;
        for (int i = 0; i < 64; i++) send(WIN'(50));
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 30; i++) send(WIN'(9));
        in_valid = 1'b0;
        x_ready  = 1'b1;
        step();
        x_ready = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_x_valid", x_valid, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_x_zero", x == '0, 1);
        repeat (3) step();
        rst_n = 1'b1;
        rv = 0;
        repeat (30) begin
            step();
            rv += int'(res_valid);
        end
        chk("rst_cancels_res", rv, 0);
        x_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(WIN'(7));
        in_valid = 1'b0;
        wait_xv();
        bad = 0;
        for (int j = 0; j < 64; j++) if (el(j) != 7) bad++;
        chk("all_seven_bad_elems", bad, 0);
        repeat (40) step();

        // Back-to-back blocks
        cnt_en = 1'b1;
        for (int i = 0; i < 192; i++) send(WIN'(500 + (i % 64)));
        in_valid = 1'b0;
        repeat (40) step();
        cnt_en = 1'b0;
        chk("b2b_res_pulses", rv_hi, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1);
    end

endmodule
